// File: rtl/sym_unpacker_4x_block_pkg.sv
// rtl/sym_unpacker_4x_block_pkg.sv - shared symbol constants and types for the byte-to-symbol unpacker
//
// Purpose: symbol geometry used by the unpacker and its stream interface.
//   SYM_W         : bits per symbol (2)
//   SYMS_PER_BYTE : symbols carried by one packed byte (4)
//   sym_t         : one received symbol
package sym_unpacker_4x_block_pkg;

  localparam int SYM_W         = 2;
  localparam int SYMS_PER_BYTE = 4;
  localparam int BYTE_W        = SYM_W * SYMS_PER_BYTE;

  typedef logic [SYM_W-1:0]  sym_t;
  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/sym_unpacker_4x_block_if.sv
// rtl/sym_unpacker_4x_block_if.sv - byte input and symbol output handshake bundle
//
// Purpose: groups the upstream byte stream and downstream symbol stream.
// Signals:
//   in_valid, in_byte, in_ready          : packed byte handshake
//   rx_sym_valid, rx_sym, rx_sym_ready   : symbol handshake
// Modports:
//   master : environment side (drives bytes, consumes symbols)
//   slave  : unpacker side (accepts bytes, produces symbols)
interface sym_unpacker_4x_block_if;
  import sym_unpacker_4x_block_pkg::*;

  logic  in_valid;
  byte_t in_byte;
  logic  in_ready;
  logic  rx_sym_valid;
  sym_t  rx_sym;
  logic  rx_sym_ready;

  modport master (
    output in_valid,
    output in_byte,
    input  in_ready,
    input  rx_sym_valid,
    input  rx_sym,
    output rx_sym_ready
  );

  modport slave (
    input  in_valid,
    input  in_byte,
    output in_ready,
    output rx_sym_valid,
    output rx_sym,
    input  rx_sym_ready
  );

endinterface

// File: rtl/sym_unpacker_4x_block.sv
// rtl/sym_unpacker_4x_block.sv - unpacks one byte into four 2-bit symbols, LSB pair first
//
// Purpose: front of the receive path; takes one packed byte per handshake and
// emits its four symbols in order B[1:0], B[3:2], B[5:4], B[7:6].
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of the byte/symbol handshake bundle
module sym_unpacker_4x_block
  import sym_unpacker_4x_block_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  sym_unpacker_4x_block_if.slave       bus
);

  localparam logic [2:0] FULL_CNT = 3'(SYMS_PER_BYTE);

  byte_t      sr;
  logic [2:0] cnt;
  logic       byte_hs;
  logic       sym_hs;

  // A new byte is only taken once every symbol of the previous one has left,
  // so byte and symbol handshakes are mutually exclusive.
  assign bus.in_ready     = !rst && (cnt == 3'd0);
  assign bus.rx_sym_valid = (cnt != 3'd0);
  assign bus.rx_sym       = sr[SYM_W-1:0];

  assign byte_hs = bus.in_valid && bus.in_ready;
  assign sym_hs  = bus.rx_sym_valid && bus.rx_sym_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cnt <= 3'd0;
    end else if (byte_hs) begin
      sr  <= bus.in_byte;
      cnt <= FULL_CNT;
    end else if (sym_hs) begin
      sr  <= sr >> SYM_W;
      cnt <= cnt - 3'd1;
    end
  end

`ifndef SYNTHESIS
  a_sym_stable : assert property (@(posedge clk) disable iff (rst)
    (bus.rx_sym_valid && !bus.rx_sym_ready) |=> ($stable(bus.rx_sym) && bus.rx_sym_valid));

  a_cnt_range : assert property (@(posedge clk) cnt <= FULL_CNT);

  a_ready_excl : assert property (@(posedge clk) !(bus.in_ready && bus.rx_sym_valid));
`endif

endmodule

// File: tb/tb_sym_unpacker_4x_block.sv
// tb/tb_sym_unpacker_4x_block.sv - directed self-checking bench for sym_unpacker_4x_block
module tb_sym_unpacker_4x_block;
  import sym_unpacker_4x_block_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sym_unpacker_4x_block_if bus ();

  sym_unpacker_4x_block dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] exp_order  [4]  = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0] exp_stream [12] = '{2'b11, 2'b10, 2'b01, 2'b00,
                                  2'b11, 2'b11, 2'b11, 2'b11,
                                  2'b00, 2'b00, 2'b00, 2'b00};
  logic [7:0] stream_bytes [3] = '{8'h1B, 8'hFF, 8'h00};
  logic [1:0] exp_after_rst [4] = '{2'b00, 2'b11, 2'b11, 2'b00};

  initial begin
    int         acc_cyc [3];
    int         si;
    int         bi;
    int         sent;
    int         got;
    bit         hs_b;
    bit         hs_s;
    logic [7:0] b;
    logic [1:0] sq [$];
    logic [1:0] e;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_byte = 8'h00;
    bus.rx_sym_ready = 1'b0;

    // Reset held for three edges
    step(); step(); step();
    check("rst_valid", 32'(bus.rx_sym_valid), 32'd0);
    check("rst_sym",   32'(bus.rx_sym),       32'd0);
    check("rst_ready", 32'(bus.in_ready),     32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);

    // Backpressure with 0xE4
    bus.in_valid = 1'b1;
    bus.in_byte = 8'hE4;
    step();
    bus.in_valid = 1'b0;
    bus.in_byte = 8'h77;
    for (int i = 0; i < 10; i++) begin
      check("bp_in_ready", 32'(bus.in_ready),     32'd0);
      check("bp_valid",    32'(bus.rx_sym_valid), 32'd1);
      check("bp_sym",      32'(bus.rx_sym),       32'd0);
      step();
    end

    // Ordering once ready is released
    bus.rx_sym_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("ord_valid", 32'(bus.rx_sym_valid), 32'd1);
      check("ord_sym",   32'(bus.rx_sym),       32'(exp_order[k]));
      step();
    end
    check("ord_done_valid", 32'(bus.rx_sym_valid), 32'd0);
    check("ord_done_ready", 32'(bus.in_ready),     32'd1);

    // Streaming with valid and ready held high
    si = 0;
    bi = 0;
    bus.in_valid = 1'b1;
    bus.in_byte = stream_bytes[0];
    for (int cyc = 0; cyc < 40 && si < 12; cyc++) begin
      hs_b = bus.in_valid && bus.in_ready;
      hs_s = bus.rx_sym_valid && bus.rx_sym_ready;
      if (hs_s) begin
        check("stream_sym", 32'(bus.rx_sym), 32'(exp_stream[si]));
        si++;
      end
      step();
      if (hs_b) begin
        acc_cyc[bi] = cyc;
        bi++;
        if (bi < 3) bus.in_byte = stream_bytes[bi];
        else        bus.in_valid = 1'b0;
      end
    end
    check("stream_count", 32'(si), 32'd12);
    check("stream_bytes", 32'(bi), 32'd3);
    if (bi == 3) begin
      check("stream_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd5);
      check("stream_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd5);
    end

    // Random ready over 100 random bytes, scoreboarded
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 3000 && !(sent == 100 && sq.size() == 0); cyc++) begin
      bus.in_valid = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.in_byte = 8'($urandom);
      bus.rx_sym_ready = 1'($urandom_range(0, 1));
      #1;
      hs_b = bus.in_valid && bus.in_ready;
      hs_s = bus.rx_sym_valid && bus.rx_sym_ready;
      if (hs_s) begin
        if (sq.size() == 0) begin
          check("rand_extra_sym", 32'd1, 32'd0);
        end else begin
          e = sq.pop_front();
          check("rand_sym", 32'(bus.rx_sym), 32'(e));
        end
        got++;
      end
      if (hs_b) begin
        b = bus.in_byte;
        for (int k = 0; k < 4; k++) sq.push_back(b[2*k +: 2]);
        sent++;
      end
      step();
    end
    check("rand_sent",  32'(sent),      32'd100);
    check("rand_got",   32'(got),       32'd400);
    check("rand_empty", 32'(sq.size()), 32'd0);

    // Mid-stream reset after two symbols of 0xA5
    bus.in_valid = 1'b0;
    bus.rx_sym_ready = 1'b0;
    step();
    bus.in_valid = 1'b1;
    bus.in_byte = 8'hA5;
    bus.rx_sym_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("a5_sym0", 32'(bus.rx_sym), 32'd1);
    step();
    check("a5_sym1", 32'(bus.rx_sym), 32'd1);
    step();
    rst = 1'b1;
    #1;
    check("mrst_ready_comb", 32'(bus.in_ready), 32'd0);
    step();
    check("mrst_valid", 32'(bus.rx_sym_valid), 32'd0);
    check("mrst_sym",   32'(bus.rx_sym),       32'd0);
    check("mrst_ready", 32'(bus.in_ready),     32'd0);
    step();
    rst = 1'b0;
    #1;
    check("mrst_release_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_byte = 8'h3C;
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("r3c_valid", 32'(bus.rx_sym_valid), 32'd1);
      check("r3c_sym",   32'(bus.rx_sym),       32'(exp_after_rst[k]));
      step();
    end
    check("r3c_done", 32'(bus.rx_sym_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
